sccb_write_master: RTL

Serialises one 32-bit SCCB write {device address, register high, register low, data} onto the camera's sclk/sda pins under a four-phase req/ack handshake. Sits directly downstream of the camera register-configuration sequencer. It receives `cfg_data`/`i2c_req` from the sequencer and returns `i2c_ack`. It runs on the 25 MHz system clock and generates SCL timing internally from a quarter-period divider.

---
 rtl/sccb_write_master.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sccb_write_master.sv
// rtl/sccb_write_master.sv - serialises one 32-bit SCCB write frame under a four-phase req/ack handshake
module sccb_write_master #(
   parameter int QTR_DIV = 63
) (
   input  logic        clk_25M,
   input  logic        rst_100,
   input  logic [31:0] cfg_data,
   input  logic        i2c_req,
   output logic        i2c_ack,
   output logic        busy,
   output logic        sclk,
   output logic        sda
);

   localparam int DW = $clog2(QTR_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(QTR_DIV - 1);

   typedef enum logic [2:0] {IDLE, START, BITS, STOP, DONE} state_t;

   state_t        state, n_state;
   logic [DW-1:0] div, n_div;
   logic [1:0]    q, n_q;
   logic [3:0]    bit_cnt, n_bit;
   logic [1:0]    byte_cnt, n_byte;
   logic [31:0]   sh, n_sh;
   logic          n_sclk, n_sda, n_ack, n_busy;
   logic          tick;

   assign tick = (div == DIV_LAST);

   // Outputs are computed for the quarter being entered, so every pin change lands on a quarter boundary.
   always_comb begin
      n_state = state;
      n_div   = div;
      n_q     = q;
      n_bit   = bit_cnt;
      n_byte  = byte_cnt;
      n_sh    = sh;
      n_sclk  = sclk;
      n_sda   = sda;
      n_ack   = i2c_ack;
      n_busy  = busy;

      if (state == START || state == BITS || state == STOP) begin
         n_div = tick ? '0 : div + DW'(1);
         if (tick) n_q = q + 2'd1;
      end

      case (state)
         IDLE: begin
            n_sclk = 1'b1;
            n_sda  = 1'b1;
            n_ack  = 1'b0;
            n_busy = 1'b0;
            if (i2c_req) begin
               n_state = START;
               n_sh    = cfg_data;
               n_div   = '0;
               n_q     = '0;
               n_bit   = '0;
               n_byte  = '0;
               n_busy  = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               if (q == 2'd1) n_sda = 1'b0;
               if (q == 2'd3) begin
                  n_state = BITS;
                  n_sclk  = 1'b0;
                  n_sda   = sh[31];
                  n_sh    = {sh[30:0], 1'b0};
               end
            end
         end
         BITS: begin
            if (tick) begin
               if (q == 2'd1) n_sclk = 1'b1;
               if (q == 2'd3) begin
                  n_sclk = 1'b0;
                  if (bit_cnt == 4'd8) begin
                     n_bit = '0;
                     if (byte_cnt == 2'd3) begin
                        n_state = STOP;
                        n_sda   = 1'b0;
                     end else begin
                        n_byte = byte_cnt + 2'd1;
                        n_sda  = sh[31];
                        n_sh   = {sh[30:0], 1'b0};
                     end
                  end else begin
                     n_bit = bit_cnt + 4'd1;
                     // Slot 8 of each byte is the don't-care bit, held high.
                     if (bit_cnt == 4'd7) begin
                        n_sda = 1'b1;
                     end else begin
                        n_sda = sh[31];
                        n_sh  = {sh[30:0], 1'b0};
                     end
                  end
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (q == 2'd1) n_sclk = 1'b1;
               if (q == 2'd2) n_sda = 1'b1;
               if (q == 2'd3) begin
                  n_state = DONE;
                  n_ack   = 1'b1;
               end
            end
         end
         DONE: begin
            n_sclk = 1'b1;
            n_sda  = 1'b1;
            n_ack  = 1'b1;
            if (!i2c_req) begin
               n_state = IDLE;
               n_ack   = 1'b0;
               n_busy  = 1'b0;
            end
         end
         default: n_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_25M) begin
      if (rst_100) begin
         state    <= IDLE;
         div      <= '0;
         q        <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         sh       <= '0;
         sclk     <= 1'b1;
         sda      <= 1'b1;
         i2c_ack  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= n_state;
         div      <= n_div;
         q        <= n_q;
         bit_cnt  <= n_bit;
         byte_cnt <= n_byte;
         sh       <= n_sh;
         sclk     <= n_sclk;
         sda      <= n_sda;
         i2c_ack  <= n_ack;
         busy     <= n_busy;
      end
   end

endmodule
